// File: rtl/tx_pkg.sv
// Shared types and constants for the UART transmit controller: state enum,
// frame length, baud-rate table and the request record latched on a write.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} tx_state_t;

  localparam int FRAME_BITS = 11;

  // Baud rates indexed by baud_sel; bit-time count is CLK_HZ / rate, truncated.
  localparam int BAUD_RATE [16] = '{
    300, 600, 1200, 2400, 4800, 9600, 19200, 38400,
    57600, 115200, 230400, 460800, 921600, 921600, 921600, 921600
  };

  typedef struct packed {
    logic [7:0] din;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud_sel;
  } tx_req_t;

endpackage

// File: rtl/tx_controller_bit_time_counter.sv
// Bit-time counter: counts while enabled, wraps at k-1 and pulses tick on the wrap.
module bit_time_counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] k,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == k - 1'b1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_controller.sv
// UART transmit controller: latches a character, loads an 11-bit frame and paces
// 11 shift strobes. TX_DOUBLE_BUFFER_EN adds a one-deep pending write buffer.
module tx_controller
  import tx_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] din,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud_sel,
  output logic       tx_rdy,
  output logic       ld,
  output logic       sh,
  output logic       bit_10,
  output logic       bit_9,
  output logic [6:0] ldata,
  output logic       bit_1,
  output logic       bit_0
);

  localparam int CNT_W = $clog2(CLK_HZ / BAUD_RATE[0] + 1);

  logic [CNT_W-1:0] baud_k [16];
  for (genvar i = 0; i < 16; i++) begin : g_baud_k
    assign baud_k[i] = CNT_W'(CLK_HZ / BAUD_RATE[i]);
  end

  tx_state_t  state_q, state_d;
  tx_req_t    hold_q, hold_d;
  logic [3:0] shcnt_q, shcnt_d;
  tx_req_t    wr_req;
  logic       tick, frame_done;

  assign wr_req     = '{din: din, eight: eight, pen: pen, ohel: ohel, baud_sel: baud_sel};
  assign frame_done = tick && (shcnt_q == 4'(FRAME_BITS - 1));
  assign ld         = (state_q == LOAD);
  assign sh         = tick;

  bit_time_counter #(.W(CNT_W)) u_btc (
    .clk  (clk),
    .rst  (reset),
    .clr  (state_q == LOAD),
    .en   (state_q == SEND),
    .k    (baud_k[hold_q.baud_sel]),
    .tick (tick)
  );

  always_comb begin
    shcnt_d = shcnt_q;
    if (state_q == LOAD) shcnt_d = '0;
    else if (tick)       shcnt_d = shcnt_q + 1'b1;
  end

`ifdef TX_DOUBLE_BUFFER_EN
  tx_req_t pend_q, pend_d;
  logic    pend_vld_q, pend_vld_d;
  logic    load_slot;

  assign tx_rdy = !pend_vld_q;

  // A frame can start from IDLE or straight off the last shift; the pending
  // entry has priority and a same-cycle write refills the freed slot.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    load_slot  = (state_q == IDLE) || frame_done;
    if (load_slot && pend_vld_q) begin
      hold_d  = pend_q;
      state_d = LOAD;
      if (write) pend_d = wr_req;
      else       pend_vld_d = 1'b0;
    end else if (load_slot && write) begin
      hold_d  = wr_req;
      state_d = LOAD;
    end else begin
      if (write && !pend_vld_q) begin
        pend_d     = wr_req;
        pend_vld_d = 1'b1;
      end
      if (frame_done)            state_d = IDLE;
      else if (state_q == LOAD)  state_d = SEND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end
`else
  assign tx_rdy = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (write) begin
        hold_d  = wr_req;
        state_d = LOAD;
      end
      LOAD:    state_d = SEND;
      SEND:    if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shcnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shcnt_q <= shcnt_d;
    end
  end

  // Parity bit lands in bit_9 for 8-bit frames, in ldata[6] for 7-bit frames.
  logic p8, p7;
  always_comb begin
    p8     = (^hold_q.din) ^ hold_q.ohel;
    p7     = (^hold_q.din[6:0]) ^ hold_q.ohel;
    bit_0  = 1'b0;
    bit_1  = hold_q.din[0];
    bit_10 = 1'b1;
    if (hold_q.eight) begin
      ldata = hold_q.din[7:1];
      bit_9 = hold_q.pen ? p8 : 1'b1;
    end else begin
      ldata = {hold_q.pen ? p7 : 1'b1, hold_q.din[6:1]};
      bit_9 = 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_controller.sv
// Self-checking bench for tx_controller: frame-field table, shift pacing,
// ignored writes, mid-frame reset; double-buffer sequence when TX_DOUBLE_BUFFER_EN.
module tb_tx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [7:0] din = '0;
  logic       eight = 1'b0, pen = 1'b0, ohel = 1'b0;
  logic [3:0] baud_sel = '0;
  logic       tx_rdy, ld, sh, bit_10, bit_9, bit_1, bit_0;
  logic [6:0] ldata;

  tx_controller #(.CLK_HZ(100_000_000)) dut (
    .clk(clk), .reset(reset), .write(write), .din(din), .eight(eight),
    .pen(pen), .ohel(ohel), .baud_sel(baud_sel), .tx_rdy(tx_rdy), .ld(ld),
    .sh(sh), .bit_10(bit_10), .bit_9(bit_9), .ldata(ldata), .bit_1(bit_1),
    .bit_0(bit_0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       eight, pen, ohel;
    logic [3:0] sel;
    int         k;
    logic [6:0] ldata;
    logic       b1, b9;
  } vec_t;

  vec_t tab [7];
  vec_t exp_q [$];
  int   total = 0, bad = 0;
  int   cyc = 0, last_evt = 0, exp_k = 0, ld_seen = 0, sh_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: each ld pops an expected frame; each sh is checked for pacing.
  initial forever begin
    vec_t e;
    @(negedge clk);
    if (!reset) begin
      if (ld && sh) chk("ld_sh_overlap", 1, 0);
      if (ld) begin
        ld_seen++;
        if (exp_q.size() == 0) chk("ld_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("bit_0", bit_0, 0);
          chk("bit_1", bit_1, e.b1);
          chk("ldata", ldata, e.ldata);
          chk("bit_9", bit_9, e.b9);
          chk("bit_10", bit_10, 1);
        end
        last_evt = cyc;
      end
      if (sh) begin
        sh_seen++;
        chk("sh_gap", cyc - last_evt, exp_k);
        last_evt = cyc;
      end
    end
  end

  task automatic start_frame(input vec_t v);
    chk("rdy_before_write", tx_rdy, 1);
    @(negedge clk);
    din = v.din; eight = v.eight; pen = v.pen; ohel = v.ohel; baud_sel = v.sel;
    write = 1'b1;
    exp_q.push_back(v);
    exp_k = v.k;
    @(negedge clk);
    write = 1'b0;
    din = 8'($urandom);
    baud_sel = 4'($urandom);
    chk("ld_latency", ld, 1);
  endtask

  task automatic wait_sh(input int n, input int k, output int got);
    got = 0;
    for (int c = 0; c < n * k + 20 && got < n; c++) begin
      @(negedge clk);
      if (sh) got++;
    end
  endtask

  task automatic run_frame(input vec_t v);
    int got;
    start_frame(v);
    chk("rdy_busy", tx_rdy, 0);
    wait_sh(11, v.k, got);
    chk("sh_count", got, 11);
    @(negedge clk);
    chk("rdy_after", tx_rdy, 1);
    chk("no_extra_ld", ld, 0);
  endtask

  initial begin
    int got, ld0, sh0;
    tab[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 4'd9,  868, 7'h52, 1'b1, 1'b0};
    tab[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 4'd12, 108, 7'h60, 1'b1, 1'b1};
    tab[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 4'd12, 108, 7'h7F, 1'b1, 1'b1};
    tab[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 4'd12, 108, 7'h00, 1'b0, 1'b1};
    tab[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 4'd12, 108, 7'h1E, 1'b0, 1'b1};
    tab[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 4'd13, 108, 7'h40, 1'b0, 1'b1};
    tab[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 4'd15, 108, 7'h40, 1'b1, 1'b1};

    #1;
    chk("rst_tx_rdy", tx_rdy, 1);
    chk("rst_ld", ld, 0);
    chk("rst_sh", sh, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tx_rdy", tx_rdy, 1);

    for (int i = 0; i < 7; i++) run_frame(tab[i]);

`ifndef TX_DOUBLE_BUFFER_EN
    // Write while busy must be dropped: one ld, 11 sh.
    ld0 = ld_seen; sh0 = sh_seen;
    start_frame(tab[2]);
    wait_sh(3, 108, got);
    @(negedge clk);
    din = 8'h55; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    wait_sh(8, 108, got);
    chk("busy_sh_rest", got, 8);
    repeat (3 * 108) @(negedge clk);
    chk("busy_single_ld", ld_seen - ld0, 1);
    chk("busy_sh_total", sh_seen - sh0, 11);
`else
    // A then B during SEND: B loads one cycle after A's 11th shift.
    ld0 = ld_seen; sh0 = sh_seen;
    start_frame(tab[1]);
    wait_sh(3, 108, got);
    @(negedge clk);
    chk("db_rdy_in_send", tx_rdy, 1);
    din = tab[4].din; eight = tab[4].eight; pen = tab[4].pen; ohel = tab[4].ohel;
    baud_sel = tab[4].sel; write = 1'b1;
    exp_q.push_back(tab[4]);
    @(negedge clk);
    write = 1'b0;
    wait_sh(8, 108, got);
    chk("db_a_rest", got, 8);
    @(negedge clk);
    chk("db_ld2_latency", ld, 1);
    wait_sh(11, 108, got);
    chk("db_b_sh", got, 11);
    repeat (4) @(negedge clk);
    chk("db_ld_total", ld_seen - ld0, 2);
    chk("db_sh_total", sh_seen - sh0, 22);
`endif

    // Reset after the 5th shift kills the frame; the next frame is normal.
    start_frame(tab[3]);
    wait_sh(5, 108, got);
    chk("pre_rst_sh", got, 5);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx_rdy", tx_rdy, 1);
    chk("midrst_ld", ld, 0);
    chk("midrst_sh", sh, 0);
    @(negedge clk);
    reset = 1'b0;
    sh0 = sh_seen;
    repeat (3 * 108) @(negedge clk);
    chk("no_sh_after_rst", sh_seen - sh0, 0);
    chk("rdy_after_rst", tx_rdy, 1);
    run_frame(tab[6]);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/tx_controller.md
TX_CONTROLLER -- requirements
Module: tx_controller

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz, used to derive bit-time counts.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 write  input  1  one-cycle strobe requesting transmission of din.
REQ-005 din  input  8  character to transmit.
REQ-006 eight  input  1  1 = 8 data bits, 0 = 7 data bits (din[6:0]).
REQ-007 pen  input  1  parity enable.
REQ-008 ohel  input  1  parity sense: 0 = even, 1 = odd.
REQ-009 baud_sel  input  4  index into the baud-rate table.
REQ-010 tx_rdy  output  1  1 = controller accepts a write.
REQ-011 ld, sh  output  1 each  one-cycle load and shift strobes to the downstream 11-bit transmit shift register.
REQ-012 bit_10, bit_9, ldata[6:0], bit_1, bit_0  output  frame fields presented with ld; frame is {bit_10, bit_9, ldata, bit_1, bit_0}, bit_0 transmitted first.

Function
REQ-013 States: IDLE, LOAD, SEND; reset enters IDLE.
REQ-014 IDLE: tx_rdy = 1; write latches din, eight, pen, ohel, baud_sel into holding registers, clears tx_rdy and enters LOAD on the next edge.
REQ-015 LOAD: ld = 1 for exactly one cycle (one cycle after the write); bit-time counter and shift counter cleared; next state SEND.
REQ-016 SEND: bit-time counter increments every cycle; when it equals K-1 it wraps to 0 and sh = 1 for one cycle; shift counter increments.
REQ-017 The 11th sh ends the frame: next state IDLE, tx_rdy = 1 on the following cycle; always 11 shifts regardless of the frame format.
REQ-018 K = BAUD_K[baud_sel] sampled at write; baud_sel changes mid-frame have no effect.
REQ-019 Frame mapping: bit_0 = 0 (start); bit_1 = D0; bit_10 = 1.
REQ-020 eight=1: ldata = D[7:1]; bit_9 = pen ? P8 : 1, where P8 = ^D[7:0] XOR ohel.
REQ-021 eight=0: ldata = {pen ? P7 : 1, D[6:1]}; bit_9 = 1, where P7 = ^D[6:0] XOR ohel.
REQ-022 Frame fields are combinational from the holding registers; they only need to be valid while ld = 1.
REQ-023 write while tx_rdy = 0 is ignored (without TX_DOUBLE_BUFFER_EN).
REQ-024 ld and sh are never asserted in the same cycle.

Reset
REQ-025 reset asserted at any time, including mid-frame: state = IDLE, counters = 0, ld = sh = 0, tx_rdy = 1, holding registers = 0, double-buffer flag cleared; no further sh pulses.

Configuration
REQ-026 Macro TX_DOUBLE_BUFFER_EN: when defined, adds a one-deep pending buffer; tx_rdy = 1 whenever the pending buffer is empty, including during SEND.
REQ-027 With TX_DOUBLE_BUFFER_EN, a write during SEND fills the pending buffer; after the 11th sh the controller enters LOAD directly (ld on the next cycle) and frees the buffer.
REQ-028 With TX_DOUBLE_BUFFER_EN, a write in the same cycle as the pending buffer transfers into LOAD is accepted into the freed buffer.
REQ-029 Without TX_DOUBLE_BUFFER_EN, behaviour is exactly as REQ-013..REQ-023.

Structure
REQ-030 Package tx_pkg holds the state enum, the FRAME_BITS = 11 constant, and the 16-entry BAUD_K table (CLK_HZ/baud, truncated): 300, 600, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; entries 13-15 repeat 921600.
REQ-031 Sub-module bit_time_counter (count, wrap at K-1, tick output) is instantiated once.

Verification
REQ-032 CLK_HZ=100e6, baud_sel=9 (K=868), din=8'hA5, eight=1, pen=1, ohel=0 -> ld 1 cycle after write; bit_0=0, bit_1=1, ldata=7'h52, bit_9=0, bit_10=1; sh every 868 cycles, 11 pulses; tx_rdy=1 after the last.
REQ-033 din=8'h41, eight=0, pen=1, ohel=1 -> ldata=7'h60, bit_1=1, bit_9=1, bit_10=1.
REQ-034 pen=0, eight=1, din=8'hFF -> ldata=7'h7F, bit_9=1.
REQ-035 Second write during SEND (no macro) -> ignored; exactly 11 sh pulses and a single ld.
REQ-036 reset asserted after the 5th sh -> tx_rdy=1 immediately; no further sh; a new write yields a normal frame.
REQ-037 TX_DOUBLE_BUFFER_EN: write A then B during SEND -> second ld exactly 1 cycle after A's 11th sh, carrying B's fields; 22 sh pulses total.
